// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the DIV unit
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Exception-cause code the control unit muxes in when div_zero fires
  localparam logic [3:0] DIV_ZERO_FLAG = 4'h7;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // rem stays below the divisor (at most 2**(WIDTH-1)), so the shifted
  // value fits WIDTH+1 bits and trial[WIDTH] is a valid borrow/sign bit.
  always_comb begin
    trial    = {rem, din} - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], din};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed divider producing HI (remainder) / LO (quotient)
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             div_start,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_end,
  output logic             div_zero,
  output logic             busy
);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dq, divisor;
  logic [WIDTH-1:0] rem_next, a_mag, b_mag;
  logic             q_bit, sign_q, sign_r, zero_flag;

  // Magnitude of the most negative value wraps to itself, read as unsigned
  assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (dq[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (div_start) state_next = (b_in == '0) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
      divisor   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_flag <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      div_end   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      div_end  <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            if (b_in == '0) begin
              zero_flag <= 1'b1;
            end else begin
              zero_flag <= 1'b0;
              dq        <= a_mag;
              divisor   <= b_mag;
              sign_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              sign_r    <= a_in[WIDTH-1];
              rem       <= '0;
              cnt       <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          // dq holds unconsumed dividend bits on the left, quotient bits on the right
          rem <= rem_next;
          dq  <= {dq[WIDTH-2:0], q_bit};
          cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          div_end  <= 1'b1;
          div_zero <= zero_flag;
          if (!zero_flag) begin
            lo_out <= sign_q ? -dq  : dq;
            hi_out <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in, b_in;
  logic        div_start;
  logic [31:0] hi_out, lo_out;
  logic        div_end, div_zero, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int end_pulses = 0;
  int e0 = 0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_hi = '0;

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .div_start (div_start),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_end   (div_end),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  always @(negedge clk) if (div_end === 1'b1) end_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Signed division from plain arithmetic; 64-bit keeps the overflow case exact
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    a_in = a;
    b_in = b;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    div_start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic exp_z);
    int t;
    t = 0;
    while (div_end !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_latency"}, 32'(edge_cnt - e0), 32'(exp_lat));
    check({tag, "_lo"}, lo_out, exp_lo);
    check({tag, "_hi"}, hi_out, exp_hi);
    check({tag, "_zero"}, {31'b0, div_zero}, {31'b0, exp_z});
  endtask

  task automatic check_pulse_clear(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_end_clear"}, {30'b0, div_end, div_zero}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    launch(a, b);
    if (b == 32'd0) begin
      wait_done(tag, 1, 1'b1);
    end else begin
      ref_div(a, b, q, r);
      exp_lo = q;
      exp_hi = r;
      wait_done(tag, 33, 1'b0);
    end
    check_pulse_clear(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int p0;

    reset = 1'b0;
    a_in = '0;
    b_in = '0;
    div_start = 1'b0;
    #2;
    check("reset_outputs", {hi_out[15:0] | lo_out[15:0], 13'b0, div_end, div_zero, busy}, 32'd0);
    check("reset_hi_lo", hi_out | lo_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("pos", 32'd100, 32'd7);
    check("pos_lo_const", lo_out, 32'h0000000E);
    check("pos_hi_const", hi_out, 32'h00000002);
    run_op("neg_a", 32'hFFFFFF9C, 32'd7);
    check("neg_a_lo_const", lo_out, 32'hFFFFFFF2);
    check("neg_a_hi_const", hi_out, 32'hFFFFFFFE);
    run_op("neg_both", 32'hFFFFFF9C, 32'hFFFFFFF9);
    check("neg_both_lo_const", lo_out, 32'h0000000E);
    check("neg_both_hi_const", hi_out, 32'hFFFFFFFE);

    run_op("pos2", 32'd100, 32'd7);
    run_op("divzero", 32'd5, 32'd0);
    check("divzero_hold_lo", lo_out, 32'd14);
    check("divzero_hold_hi", hi_out, 32'd2);

    run_op("overflow", 32'h80000000, 32'hFFFFFFFF);
    check("overflow_lo_const", lo_out, 32'h80000000);
    check("overflow_hi_const", hi_out, 32'd0);
    run_op("small", 32'd7, 32'd100);
    check("small_lo_const", lo_out, 32'd0);
    check("small_hi_const", hi_out, 32'd7);

    // A start while busy is dropped; a start in the div_end cycle is taken
    p0 = end_pulses;
    launch(32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    a_in = 32'd9;
    b_in = 32'd3;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    exp_lo = 32'd14;
    exp_hi = 32'd2;
    wait_done("ignore", 33, 1'b0);
    launch(32'hFFFFFF9C, 32'd7);
    exp_lo = 32'hFFFFFFF2;
    exp_hi = 32'hFFFFFFFE;
    wait_done("b2b", 33, 1'b0);
    check_pulse_clear("b2b");
    repeat (40) @(posedge clk);
    #1;
    check("ignore_pulse_count", 32'(end_pulses - p0), 32'd2);

    // Asynchronous reset mid-calculation abandons the divide
    p0 = end_pulses;
    launch(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_lo", lo_out, 32'd0);
    check("midreset_hi", hi_out, 32'd0);
    check("midreset_flags", {29'b0, div_end, div_zero, busy}, 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_end", 32'(end_pulses - p0), 32'd0);
    exp_lo = '0;
    exp_hi = '0;
    run_op("after_reset", 32'hFFFFFFF7, 32'd2);
    check("after_reset_lo_const", lo_out, 32'hFFFFFFFC);
    check("after_reset_hi_const", hi_out, 32'hFFFFFFFF);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($signed(6'($urandom)));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >>> $urandom_range(0, 31);
      run_op("random", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
